// File: rtl/alu64_seq.sv
// alu64_seq: runs 64-bit add/sub/and/xor as two passes
// through an external 32-bit combinational ALU.
`timescale 1ns/1ps
module alu64_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_cmd,
   input  logic [63:0] req_a,
   input  logic [63:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_cout,
   output logic        rsp_zero,
   output logic [3:0]  alu_op,
   output logic [31:0] alu_in0,
   output logic [31:0] alu_in1,
   output logic        alu_cin,
   input  logic [32:0] alu_F,
   input  logic        alu_cout,
   input  logic        alu_zero
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   state_t      state, nstate;
   logic [1:0]  cmd;
   logic [63:0] a, b;
   logic [31:0] res_lo;
   logic        c;
   logic        logic_op;
   logic [63:0] res_nxt;
   logic        cout_nxt;
   logic        unused_alu;

   assign unused_alu = ^{alu_zero, alu_F[32]};

   assign logic_op  = cmd[1];
   assign res_nxt   = {alu_F[31:0], res_lo};
   // ALU adds cin into in1 in 32 bits, so a carry
   // out of b_hi+1 is lost and must be restored here.
   assign cout_nxt  = ~logic_op &
                      (alu_cout | (c & (&b[63:32])));
   assign req_ready = (state == IDLE) & ~rst;
   assign rsp_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      unique case (state)
         IDLE: if (req_valid) nstate = LO;
         LO:   nstate = HI;
         HI:   nstate = DONE;
         DONE: if (rsp_ready) nstate = IDLE;
      endcase
   end

   always_comb begin
      alu_op  = 4'b1111;
      alu_in0 = '0;
      alu_in1 = '0;
      alu_cin = 1'b0;
      unique case (state)
         LO: begin
            alu_in0 = a[31:0];
            alu_in1 = b[31:0];
            unique case (cmd)
               2'b00: alu_op = 4'b0000;
               2'b01: alu_op = 4'b0010;
               2'b10: alu_op = 4'b1011;
               2'b11: alu_op = 4'b1101;
            endcase
         end
         HI: begin
            alu_in0 = a[63:32];
            alu_in1 = b[63:32];
            alu_cin = c;
            unique case (cmd)
               2'b00: alu_op = 4'b0001;
               2'b01: alu_op = 4'b0011;
               2'b10: alu_op = 4'b1011;
               2'b11: alu_op = 4'b1101;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd        <= '0;
         a          <= '0;
         b          <= '0;
         res_lo     <= '0;
         c          <= 1'b0;
         rsp_result <= '0;
         rsp_cout   <= 1'b0;
         rsp_zero   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  cmd <= req_cmd;
                  a   <= req_a;
                  b   <= req_b;
               end
            end
            LO: begin
               res_lo <= alu_F[31:0];
               c      <= alu_cout & ~logic_op;
            end
            HI: begin
               rsp_result <= res_nxt;
               rsp_cout   <= cout_nxt;
               rsp_zero   <= (res_nxt == 64'd0);
            end
            DONE: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu64_seq.sv
// tb_alu64_seq: directed scoreboard bench for alu64_seq
// with a behavioural 32-bit ALU on the alu_* ports.
`timescale 1ns/1ps
module tb_alu64_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_cmd;
   logic [63:0] req_a, req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_result;
   logic        rsp_cout;
   logic        rsp_zero;
   logic [3:0]  alu_op;
   logic [31:0] alu_in0, alu_in1;
   logic        alu_cin;
   logic [32:0] alu_F;
   logic        alu_cout;
   logic        alu_zero;
   logic [31:0] alu_t;

   typedef struct packed {
      logic [63:0] r;
      logic        c;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   alu64_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout),
      .rsp_zero(rsp_zero),
      .alu_op(alu_op), .alu_in0(alu_in0),
      .alu_in1(alu_in1), .alu_cin(alu_cin),
      .alu_F(alu_F), .alu_cout(alu_cout),
      .alu_zero(alu_zero)
   );

   // 32-bit ALU: in1+cin is formed in 32 bits first
   assign alu_t = alu_in1 + {31'd0, alu_cin};
   always_comb begin
      alu_F = '0;
      case (alu_op)
         4'b0000, 4'b0001:
            alu_F = {1'b0, alu_in0} + {1'b0, alu_t};
         4'b0010, 4'b0011:
            alu_F = {1'b0, alu_in0} - {1'b0, alu_t};
         4'b1011: alu_F = {1'b0, alu_in0 & alu_in1};
         4'b1101: alu_F = {1'b0, alu_in0 ^ alu_in1};
         default: alu_F = '0;
      endcase
   end
   assign alu_cout = alu_F[32];
   assign alu_zero = (alu_F[31:0] == 32'd0);

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] cmd,
                                  input logic [63:0] a,
                                  input logic [63:0] b);
      logic [64:0] w;
      exp_t e;
      case (cmd)
         2'b00: w = {1'b0, a} + {1'b0, b};
         2'b01: w = {1'b0, a} - {1'b0, b};
         2'b10: w = {1'b0, a & b};
         default: w = {1'b0, a ^ b};
      endcase
      e.r = w[63:0];
      e.c = w[64];
      e.z = (w[63:0] == 64'd0);
      return e;
   endfunction

   function automatic logic lo_carry(input logic [1:0] cmd,
                                     input logic [63:0] a,
                                     input logic [63:0] b);
      logic [32:0] s;
      s = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      case (cmd)
         2'b00: return s[32];
         2'b01: return a[31:0] < b[31:0];
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] op_lo(input logic [1:0] cmd);
      case (cmd)
         2'b00: return 4'b0000;
         2'b01: return 4'b0010;
         2'b10: return 4'b1011;
         default: return 4'b1101;
      endcase
   endfunction

   function automatic logic [3:0] op_hi(input logic [1:0] cmd);
      case (cmd)
         2'b00: return 4'b0001;
         2'b01: return 4'b0011;
         2'b10: return 4'b1011;
         default: return 4'b1101;
      endcase
   endfunction

   task automatic issue(input logic [1:0] cmd,
                        input logic [63:0] a,
                        input logic [63:0] b);
      int n = 0;
      req_cmd   = cmd;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 64'(n < 20), 64'd1);
      sb.push_back(model(cmd, a, b));
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic check_lohi(input logic [1:0] cmd,
                             input logic [63:0] a,
                             input logic [63:0] b);
      chk("lo_op",    64'(alu_op),  64'(op_lo(cmd)));
      chk("lo_in0",   64'(alu_in0), 64'(a[31:0]));
      chk("lo_in1",   64'(alu_in1), 64'(b[31:0]));
      chk("lo_cin",   64'(alu_cin), 64'd0);
      chk("lo_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("hi_op",    64'(alu_op),  64'(op_hi(cmd)));
      chk("hi_in0",   64'(alu_in0), 64'(a[63:32]));
      chk("hi_in1",   64'(alu_in1), 64'(b[63:32]));
      chk("hi_cin",   64'(alu_cin), 64'(lo_carry(cmd, a, b)));
      chk("hi_valid", 64'(rsp_valid), 64'd0);
   endtask

   task automatic collect(input int hold);
      int   n = 0;
      exp_t e;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_latency", 64'(n), 64'd1);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid",  64'(rsp_valid), 64'd1);
         chk("hold_result", rsp_result, e.r);
         chk("hold_cout",   64'(rsp_cout), 64'(e.c));
         chk("hold_ready",  64'(req_ready), 64'd0);
         chk("hold_aluop",  64'(alu_op), 64'hF);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      chk("rsp_valid",  64'(rsp_valid), 64'd1);
      chk("rsp_result", rsp_result, e.r);
      chk("rsp_cout",   64'(rsp_cout), 64'(e.c));
      chk("rsp_zero",   64'(rsp_zero), 64'(e.z));
      chk("hs_ready",   64'(req_ready), 64'd0);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_valid", 64'(rsp_valid), 64'd0);
      chk("post_ready", 64'(req_ready), 64'd1);
   endtask

   task automatic run_op(input logic [1:0] cmd,
                         input logic [63:0] a,
                         input logic [63:0] b);
      issue(cmd, a, b);
      check_lohi(cmd, a, b);
      collect(0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 2'b00;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid",  64'(rsp_valid), 64'd0);
      chk("rst_result", rsp_result, 64'd0);
      chk("rst_cout",   64'(rsp_cout), 64'd0);
      chk("rst_zero",   64'(rsp_zero), 64'd0);
      chk("rst_ready",  64'(req_ready), 64'd0);
      chk("rst_aluop",  64'(alu_op), 64'hF);
      rst = 1'b0;
      #1;
      chk("rel_ready", 64'(req_ready), 64'd1);
      @(negedge clk);

      run_op(2'b00, 64'h00000000_FFFFFFFF, 64'h1);
      run_op(2'b00, 64'h1, 64'hFFFFFFFF_FFFFFFFF);
      run_op(2'b01, 64'h00000001_00000000, 64'h1);
      run_op(2'b01, 64'h0, 64'h1);
      run_op(2'b01, 64'h0, 64'hFFFFFFFF_FFFFFFFF);
      run_op(2'b11, 64'h12345678_9ABCDEF0,
                    64'h12345678_9ABCDEF0);
      run_op(2'b10, 64'hFFFF0000_FFFF0000,
                    64'h0F0F0F0F_0F0F0F0F);
      run_op(2'b00, 64'h89ABCDEF_80000000,
                    64'h76543210_80000000);

      // backpressure with a request waiting upstream
      issue(2'b00, 64'hDEADBEEF_00000001,
                   64'h00000001_FFFFFFFF);
      check_lohi(2'b00, 64'hDEADBEEF_00000001,
                        64'h00000001_FFFFFFFF);
      req_cmd   = 2'b01;
      req_a     = 64'h5;
      req_b     = 64'h7;
      req_valid = 1'b1;
      collect(5);
      chk("b2b_ready", 64'(req_ready), 64'd1);
      issue(2'b01, 64'h5, 64'h7);
      check_lohi(2'b01, 64'h5, 64'h7);
      collect(0);

      // reset while in HI abandons the operation
      issue(2'b00, 64'h3, 64'h4);
      @(negedge clk);
      chk("mid_hi_op", 64'(alu_op), 64'b0001);
      rst = 1'b1;
      @(negedge clk);
      chk("ab_valid",  64'(rsp_valid), 64'd0);
      chk("ab_result", rsp_result, 64'd0);
      chk("ab_cout",   64'(rsp_cout), 64'd0);
      chk("ab_zero",   64'(rsp_zero), 64'd0);
      chk("ab_aluop",  64'(alu_op), 64'hF);
      chk("ab_ready",  64'(req_ready), 64'd0);
      rst = 1'b0;
      #1;
      chk("ab_rel_ready", 64'(req_ready), 64'd1);
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ab_no_rsp", 64'(rsp_valid), 64'd0);
      end
      run_op(2'b00, 64'h1, 64'h1);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/alu64_seq.md
# alu64_seq

Multi-cycle sequencer that executes 64-bit operations on the shared 32-bit ALU by issuing two ALU passes: low word first, then high word with the inter-word carry/borrow. It sits between an upstream requester (valid/ready) and the combinational 32-bit ALU, which it drives through dedicated ports. It also captures the result and produces corrected 64-bit flags.

## Interface
- No parameters.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state==IDLE) & ~rst.
- req_cmd  in  2  00 ADD64, 01 SUB64 (a−b), 10 AND64, 11 XOR64.
- req_a, req_b  in  64  operands.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  64  result.
- rsp_cout  out  1  64-bit carry (ADD) / borrow (SUB, 1 when a<b unsigned); 0 for logic ops.
- rsp_zero  out  1  rsp_result == 0.
- alu_op  out  4  ALU opcode.
- alu_in0, alu_in1  out  32  ALU operands.
- alu_cin  out  1  ALU carry-in.
- alu_F  in  33  ALU result; bit 32 is the ALU's carry/borrow.
- alu_cout  in  1  ALU carry flag (== alu_F[32]).
- alu_zero  in  1  unused.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE: on req_valid & req_ready, latch cmd, a, b; go to LO.
- LO: in0=a[31:0], in1=b[31:0], cin=0; op = 0000 (ADD), 0010 (SUB), 1011 (AND), 1101 (XOR). At the clock edge: res_lo <= alu_F[31:0], c <= alu_cout (forced 0 for logic ops); go to HI.
- HI: in0=a[63:32], in1=b[63:32], cin=c; op = 0001 (ADD), 0011 (SUB), same as LO for logic ops. At the clock edge: result <= {alu_F[31:0], res_lo}; go to DONE.
- Carry correction: the ALU forms in1+cin in 32 bits, so it loses the carry when b_hi==FFFFFFFF and c==1.
  - ADD: rsp_cout = alu_cout | (c & b_hi==32'hFFFFFFFF).
  - SUB: rsp_cout = alu_cout | (c & b_hi==32'hFFFFFFFF).
  - The data result is already correct modulo 2^64.
- rsp_zero is computed from the 64-bit result, not from alu_zero. The result and flags are registered at the HI edge.
- DONE: rsp_valid=1. rsp_result, rsp_cout and rsp_zero are held stable until rsp_valid & rsp_ready, then the block returns to IDLE.
- ALU drive outside LO/HI: op=1111, in0=in1=0, cin=0.
- Reset: state=IDLE, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=0, all internal registers 0.
  - Reset in any state abandons the operation; no response is produced.

## Timing
- Request accepted at edge N (LO during cycle N+1, HI during cycle N+2). rsp_valid rises after edge N+2 and is visible in cycle N+3.
- The ALU is combinational: alu_F is sampled at the same edge that ends its LO/HI cycle.
- req_ready is 0 in LO, HI and DONE. No request is taken in the cycle of the response handshake. The earliest next accept is the cycle after rsp handshake, so minimum issue interval is 4 cycles.
- Operands, ALU outputs and the response hold steady regardless of req_valid changes while the block is busy.
- rsp_valid, once set, never drops without rsp_ready (except rst).

## Test plan
- ADD64 a=0x00000000_FFFFFFFF, b=0x1 → result 0x00000001_00000000, cout=0, zero=0. rsp_valid exactly 3 cycles after accept. alu_op sequence 0000, 0001 with alu_cin=1 in HI.
- ADD64 a=0x1, b=0xFFFFFFFF_FFFFFFFF (correction path) → result 0, cout=1, zero=1.
- SUB64:
  - a=0x00000001_00000000, b=0x1 → 0x00000000_FFFFFFFF, cout=0.
  - a=0, b=0x1 → 0xFFFFFFFF_FFFFFFFF, cout=1.
  - a=0, b=0xFFFFFFFF_FFFFFFFF → 0x1, cout=1 (correction).
- Logic ops:
  - XOR64 a=b=0x12345678_9ABCDEF0 → result 0, zero=1, cout=0.
  - AND64 a=0xFFFF0000_FFFF0000, b=0x0F0F0F0F_0F0F0F0F → 0x0F0F0000_0F0F0000, zero=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE.
  - Response stays stable and req_ready stays 0.
  - A back-to-back req_valid is accepted only in the cycle after the handshake, and yields the correct result.
- Reset mid-op: assert rst for 1 cycle while in HI.
  - All outputs go to 0 and req_ready returns to 1, with no rsp_valid for the aborted request.
  - The next ADD64 1+1 returns 2.
